// File: rtl/genit_lane_arb.sv
// genit_lane_arb
//   Round-robin arbiter sharing one fixed-latency 1-bit lane among NREQ
//   requesters. A winner's sample is driven onto lane_value. A tag
//   pipeline, matched to the lane latency, carries the winner's index so
//   that the lane result is routed back to the requester that issued it.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   enable       permits new grants; the tag pipeline keeps draining when low
//   req          per-requester level request
//   value_in     per-requester sample bit
//   gnt          registered one-hot grant
//   lane_value   sample driven into the shared lane (holds when idle)
//   lane_result  lane output, valid LAT cycles after lane_value
//   rsp_valid    registered one-hot response strobe
//   rsp_result   returned lane result (holds when no response)
//   issue_cnt    wrapping count of grants since reset
module genit_lane_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] value_in,
  output logic [NREQ-1:0] gnt,
  output logic            lane_value,
  input  logic            lane_result,
  output logic [NREQ-1:0] rsp_valid,
  output logic            rsp_result,
  output logic [7:0]      issue_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]          ptr;
  logic [IW-1:0]          cand;
  logic [IW-1:0]          win_idx;
  logic [IW-1:0]          ptr_nxt;
  logic                   win;
  logic                   grant_ok;

  // Tag pipeline: stage s is valid in the s-th cycle after the grant, so
  // stage LAT lines up with the matching lane_result.
  logic [LAT:0]           vld_pipe;
  logic [LAT:0][IW-1:0]   idx_pipe;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Rotating priority scan starting at ptr; first set request wins.
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int o = 0; o < NREQ; o++) begin
      cand = IW'((int'(ptr) + o) % NREQ);
      if (!win && req[cand]) begin
        win     = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign grant_ok = enable & win;
  assign ptr_nxt  = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt        <= '0;
      lane_value <= 1'b0;
      issue_cnt  <= '0;
      ptr        <= '0;
      vld_pipe   <= '0;
      idx_pipe   <= '0;
      rsp_valid  <= '0;
      rsp_result <= 1'b0;
    end else begin
      gnt <= grant_ok ? onehot(win_idx) : '0;
      if (grant_ok) begin
        lane_value <= value_in[win_idx];
        issue_cnt  <= issue_cnt + 8'd1;
        ptr        <= ptr_nxt;
      end

      // Shifts every cycle regardless of enable so in-flight samples drain.
      vld_pipe[0] <= grant_ok;
      idx_pipe[0] <= win_idx;
      for (int s = 1; s <= LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end

      rsp_valid <= vld_pipe[LAT] ? onehot(idx_pipe[LAT]) : '0;
      if (vld_pipe[LAT])
        rsp_result <= lane_result;
    end
  end

endmodule

// File: tb/tb_genit_lane_arb.sv
// Directed bench for genit_lane_arb: a vector table covering single-request,
// full contention, enable stall and fairness, plus hand sequences for reset
// mid-flight, counter wrap and a LAT=1 instance.
module tb_genit_lane_arb;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] value_in;

  logic [NREQ-1:0] gnt, rsp_valid;
  logic            lane_value, lane_result, rsp_result;
  logic [7:0]      issue_cnt;

  logic [NREQ-1:0] gnt1, rsp_valid1;
  logic            lane_value1, lane_result1, rsp_result1;
  logic [7:0]      issue_cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genit_lane_arb #(.NREQ(NREQ), .LAT(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .value_in(value_in),
    .gnt(gnt), .lane_value(lane_value), .lane_result(lane_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .issue_cnt(issue_cnt)
  );

  genit_lane_arb #(.NREQ(NREQ), .LAT(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .value_in(value_in),
    .gnt(gnt1), .lane_value(lane_value1), .lane_result(lane_result1),
    .rsp_valid(rsp_valid1), .rsp_result(rsp_result1), .issue_cnt(issue_cnt1)
  );

  // Lane models: pure delays of LAT cycles, not reset.
  logic [1:0] dl  = '0;
  logic       dl1 = 1'b0;
  always @(posedge clk) begin
    dl  <= {dl[0], lane_value};
    dl1 <= lane_value1;
  end
  assign lane_result  = dl[1];
  assign lane_result1 = dl1;

  typedef struct {
    logic [3:0] req;
    logic [3:0] val;
    logic       en;
    logic [3:0] gnt;
    logic       lv;
    logic [3:0] rv;
    logic       rr;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic [3:0] r, logic [3:0] v, logic e, logic [3:0] g,
                              logic l, logic [3:0] rv, logic rr, logic [7:0] c);
    mk = '{r, v, e, g, l, rv, rr, c};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] lat1_rv [4];
    logic       lat1_rr [4];
    lat1_rv = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
    lat1_rr = '{1'b0, 1'b0, 1'b1, 1'b1};

    //          req      val      en  gnt      lv  rsp_v    rr  cnt
    tbl[0]  = mk(4'b0001, 4'b0001, 1, 4'b0001, 1, 4'b0000, 0, 1);
    tbl[1]  = mk(4'b0000, 4'b0001, 1, 4'b0000, 1, 4'b0000, 0, 1);
    tbl[2]  = mk(4'b0000, 4'b0001, 1, 4'b0000, 1, 4'b0000, 0, 1);
    tbl[3]  = mk(4'b0000, 4'b0001, 1, 4'b0000, 1, 4'b0001, 1, 1);
    tbl[4]  = mk(4'b1111, 4'b1010, 1, 4'b0010, 1, 4'b0000, 1, 2);
    tbl[5]  = mk(4'b1111, 4'b1010, 1, 4'b0100, 0, 4'b0000, 1, 3);
    tbl[6]  = mk(4'b1111, 4'b1010, 1, 4'b1000, 1, 4'b0000, 1, 4);
    tbl[7]  = mk(4'b1111, 4'b1010, 1, 4'b0001, 0, 4'b0010, 1, 5);
    tbl[8]  = mk(4'b1111, 4'b1010, 1, 4'b0010, 1, 4'b0100, 0, 6);
    tbl[9]  = mk(4'b1111, 4'b1010, 1, 4'b0100, 0, 4'b1000, 1, 7);
    tbl[10] = mk(4'b1111, 4'b1010, 1, 4'b1000, 1, 4'b0001, 0, 8);
    tbl[11] = mk(4'b1111, 4'b1010, 1, 4'b0001, 0, 4'b0010, 1, 9);
    tbl[12] = mk(4'b1111, 4'b1010, 0, 4'b0000, 0, 4'b0100, 0, 9);
    tbl[13] = mk(4'b1111, 4'b1010, 0, 4'b0000, 0, 4'b1000, 1, 9);
    tbl[14] = mk(4'b1111, 4'b1010, 0, 4'b0000, 0, 4'b0001, 0, 9);
    tbl[15] = mk(4'b1111, 4'b1010, 1, 4'b0010, 1, 4'b0000, 0, 10);
    tbl[16] = mk(4'b0101, 4'b1010, 1, 4'b0100, 0, 4'b0000, 0, 11);
    tbl[17] = mk(4'b0101, 4'b1010, 1, 4'b0001, 0, 4'b0000, 0, 12);
    tbl[18] = mk(4'b0101, 4'b1010, 1, 4'b0100, 0, 4'b0010, 1, 13);
    tbl[19] = mk(4'b0111, 4'b1010, 1, 4'b0001, 0, 4'b0100, 0, 14);
    tbl[20] = mk(4'b0111, 4'b1010, 1, 4'b0010, 1, 4'b0001, 0, 15);
    tbl[21] = mk(4'b0000, 4'b1010, 1, 4'b0000, 1, 4'b0100, 0, 15);
    tbl[22] = mk(4'b0000, 4'b1010, 1, 4'b0000, 1, 4'b0001, 0, 15);
    tbl[23] = mk(4'b0000, 4'b1010, 1, 4'b0000, 1, 4'b0010, 1, 15);
    tbl[24] = mk(4'b0000, 4'b1010, 1, 4'b0000, 1, 4'b0000, 1, 15);

    reset = 1'b1; enable = 1'b1; req = '0; value_in = '0;
    step(); step();
    chk("reset_gnt", gnt, 0);
    chk("reset_lane_value", lane_value, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_issue_cnt", issue_cnt, 0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      req = tbl[i].req; value_in = tbl[i].val; enable = tbl[i].en;
      step();
      chk($sformatf("row%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("row%0d_lane_value", i), lane_value, tbl[i].lv);
      chk($sformatf("row%0d_rsp_valid", i), rsp_valid, tbl[i].rv);
      chk($sformatf("row%0d_rsp_result", i), rsp_result, tbl[i].rr);
      chk($sformatf("row%0d_issue_cnt", i), issue_cnt, tbl[i].cnt);
      if (i < 4) begin
        chk($sformatf("lat1_row%0d_rsp_valid", i), rsp_valid1, lat1_rv[i]);
        chk($sformatf("lat1_row%0d_rsp_result", i), rsp_result1, lat1_rr[i]);
      end
    end

    // Reset mid-flight: three grants from pointer 2, then reset with req high.
    req = 4'b1111; value_in = 4'b1111; enable = 1'b1;
    step(); chk("mf_gnt0", gnt, 4'b0100);
    step(); chk("mf_gnt1", gnt, 4'b1000);
    step(); chk("mf_gnt2", gnt, 4'b0001);
    reset = 1'b1;
    step();
    chk("mf_reset_gnt", gnt, 0);
    chk("mf_reset_lane_value", lane_value, 0);
    chk("mf_reset_rsp_valid", rsp_valid, 0);
    chk("mf_reset_rsp_result", rsp_result, 0);
    chk("mf_reset_issue_cnt", issue_cnt, 0);
    reset = 1'b0; req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("mf_no_rsp%0d", i), rsp_valid, 0);
    end
    req = 4'b1111;
    step();
    chk("mf_regrant_gnt", gnt, 4'b0001);
    chk("mf_regrant_cnt", issue_cnt, 1);
    req = '0;

    // Counter wrap with a single requester held high.
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      step();
      chk($sformatf("wrap_gnt%0d", i), gnt, 4'b0001);
      if (i == 254) chk("wrap_cnt255", issue_cnt, 255);
      if (i == 255) chk("wrap_cnt0", issue_cnt, 0);
    end
    req = '0;
    step();
    chk("idle_gnt", gnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/genit_lane_arb.md
# genit_lane_arb

Round-robin arbiter that shares one generated `Test` lane (1-bit `value` in, 1-bit `result` out, fixed pipeline latency) among several requesters. It sits beside the `genit` generate wrapper. It accepts per-requester issue requests, drives the lane's `value` input, tracks each in-flight sample with a latency-matched tag pipeline, and routes each lane result back to the requester that issued it.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `LAT`, 2, lane latency in cycles from `lane_value` presented to matching `lane_result` valid (1..8)
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `enable`  input  1  high permits new grants; low blocks issue while the in-flight pipeline drains
- `req`  input  NREQ  per-requester issue request, level-sensitive
- `value_in`  input  NREQ  bit i is requester i's sample value
- `gnt`  output  NREQ  one-hot registered grant; at most one bit high per cycle
- `lane_value`  output  1  value driven into the shared lane
- `lane_result`  input  1  lane output
- `rsp_valid`  output  NREQ  one-hot registered response strobe
- `rsp_result`  output  1  returned lane result, qualified by `rsp_valid`
- `issue_cnt`  output  8  total grants issued since reset, wraps

## Operation
- Reset values: `gnt`=0, `lane_value`=0, `rsp_valid`=0, `rsp_result`=0, `issue_cnt`=0, round-robin pointer=0, all tag-pipeline stages invalid.
- Arbitration at each edge with `reset` low and `enable` high: scan `req` starting at the pointer, wrapping modulo NREQ. The first set bit i wins.
- On a win, the following are registered:
  - `gnt`=one-hot(i)
  - `lane_value`=`value_in[i]`
  - `issue_cnt`+=1, 8-bit wrap 255->0
  - pointer=(i+1) mod NREQ
- If no bit of `req` is set, or `enable` is low: `gnt`=0, `lane_value` holds its previous value, pointer and counter are unchanged.
- A requester keeps `req` high until it sees `gnt`. If it keeps `req` high after being granted, it is granted again only after every other active requester has been served.
- Dropping `req` before a grant withdraws the request. No state is kept for it.
- Tag pipeline: LAT+1 stages, each holding a valid bit and a requester index. Stage 0 loads {valid=any grant, index=i} in the grant cycle. The tag shifts one stage per cycle unconditionally; `enable` does not stall it.
- Response: when the last tag stage is valid with index k, on the next edge `rsp_valid`=one-hot(k) and `rsp_result`=`lane_result` as sampled at that edge. Otherwise `rsp_valid`=0 and `rsp_result` holds.
- Back-to-back grants to different requesters produce back-to-back responses in grant order. No reordering, no loss.
- Reset mid-flight: all tags are invalidated. No `rsp_valid` may appear for samples issued before reset, even if the lane still produces results.
- Simultaneous `reset` and `req`: reset wins and no grant is issued that cycle.

## Timing
- Grant latency: `req` high before edge E gives `gnt` and `lane_value` valid in the cycle after E (call it cycle G).
- The lane presents the matching `lane_result` in cycle G+LAT.
- `rsp_valid` and `rsp_result` are valid in cycle G+LAT+1. Total request-to-response latency is LAT+2 edges.
- Throughput is one issue per cycle with no bubbles while requests are present.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Single requester, NREQ=4, LAT=2: `req`=0001 and `value_in`=0001 for one cycle, lane modelled as a 2-cycle delay -> `gnt`=0001 in cycle 1; `rsp_valid`=0001 with `rsp_result`=1 in cycle 4; `issue_cnt`=1.
- Full contention: `req`=1111 held for 8 cycles -> `gnt` sequence 0001,0010,0100,1000 repeating. Responses follow the same order, each LAT+1 cycles after its grant, with no gaps. `issue_cnt`=8.
- Fairness after pointer advance: `req`=0101 held -> grants alternate 0001,0100. Add `req[1]` mid-run -> it is granted within 2 cycles.
- `enable` low for 3 cycles with `req`=1111 -> `gnt`=0 for those 3 cycles. Responses for already-issued samples still arrive. Issue resumes at the saved pointer.
- Reset mid-flight: grant 3 samples, assert `reset` for one cycle immediately after the last grant -> no `rsp_valid` afterwards; all outputs return to reset values; the next grant goes to requester 0 first.
- Counter wrap: 256 consecutive grants -> `issue_cnt` reads 255 then 0. Repeat the single-requester case with LAT=1 -> response in cycle 3.
